// File: rtl/serial_greater.sv
// serial_greater: bit-serial two's-complement comparator, MSB (sign) first.
// Optional build macro SERIAL_GREATER_EARLY_DONE_EN: finish on the beat
// that decides GT/LT instead of always consuming WIDTH beats.
module serial_greater #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] greater_result,
    output logic             less,
    output logic             equal
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SIGN, BODY, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          dec, gt;        // decision so far (dec=1 once bits differed)
    logic          dec_nx, gt_nx;
    logic          beat, diff, fin, arm;
    logic          gt_q, lt_q, eq_q, done_q;

    // beat qualification, decision update and next-state selection
    always_comb begin
        beat     = ((state == SIGN) || (state == BODY)) && bit_valid;
        diff     = a_bit ^ b_bit;
        arm      = start && ((state == IDLE) || (state == DONE));
        dec_nx   = dec;
        gt_nx    = gt;
        if (beat && !dec && diff) begin
            dec_nx = 1'b1;
            // sign beat: A negative loses; body beat: the one-bit wins
            gt_nx  = (state == SIGN) ? b_bit : a_bit;
        end
`ifdef SERIAL_GREATER_EARLY_DONE_EN
        fin = beat && ((cnt == CW'(WIDTH - 1)) || (!dec && diff));
`else
        fin = beat && (cnt == CW'(WIDTH - 1));
`endif
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = SIGN;
            SIGN: if (beat)  state_nx = fin ? DONE : BODY;
            BODY: if (fin)   state_nx = DONE;
            DONE: if (start) state_nx = SIGN;
            default:         state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // bit counter, running decision and registered results
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            dec    <= 1'b0;
            gt     <= 1'b0;
            done_q <= 1'b0;
            gt_q   <= 1'b0;
            lt_q   <= 1'b0;
            eq_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (arm) begin
                cnt <= '0;
                dec <= 1'b0;
                gt  <= 1'b0;
            end else if (beat) begin
                cnt <= cnt + CW'(1);
                dec <= dec_nx;
                gt  <= gt_nx;
            end
            // results replace the held ones only when a compare completes
            if (fin) begin
                done_q <= 1'b1;
                gt_q   <= dec_nx & gt_nx;
                lt_q   <= dec_nx & ~gt_nx;
                eq_q   <= ~dec_nx;
            end
        end
    end

    assign busy           = (state == SIGN) || (state == BODY);
    assign done           = done_q;
    assign greater_result = {{(WIDTH - 1){1'b0}}, gt_q};
    assign less           = lt_q;
    assign equal          = eq_q;

endmodule

// File: tb/tb_serial_greater.sv
// Directed table plus corner sequences and a full 6-bit sweep for serial_greater.
module tb_serial_greater;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset, start, bit_valid, a_bit, b_bit;
    logic         busy, done, less, equal;
    logic [W-1:0] greater_result;

    int total = 0;
    int bad   = 0;

    // results expected to be held going into the next compare
    int pg = 0, pl = 0, pe = 0;

    serial_greater #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid),
        .a_bit(a_bit), .b_bit(b_bit), .busy(busy), .done(done),
        .greater_result(greater_result), .less(less), .equal(equal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           stall_at;  // bit index before which stalls are inserted (-1 none)
        int           nst;
        int           poke;      // cycle at which start is pulsed mid-compare (-1 none)
        int           eg, el, ee;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // expected latency from the start cycle to the done cycle
    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input int stall_at, input int nst);
        int need, st;
        need = W;
`ifdef SERIAL_GREATER_EARLY_DONE_EN
        for (int p = 0; p < W; p++)
            if (a[W-1-p] != b[W-1-p] && need == W) need = p + 1;
`endif
        st = (stall_at >= 0 && (W - 1 - stall_at) < need) ? nst : 0;
        return need + 1 + st;
    endfunction

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int stall_at, input int nst, input int poke,
                       input int eg, input int el, input int ee);
        int cyc, i, st;
        @(negedge clk);
        start = 1'b1; bit_valid = 1'b0; cyc = 0;
        @(negedge clk);
        start = 1'b0; cyc = 1; i = W - 1; st = 0;
        chk("held_gt", int'(greater_result), pg);
        chk("held_lt", int'(less), pl);
        chk("held_eq", int'(equal), pe);
        while (!done && cyc < 40) begin
            chk("busy", int'(busy), 1);
            start = (cyc == poke);
            if (i >= 0) begin
                if (i == stall_at && st < nst) begin
                    bit_valid = 1'b0; st++;
                end else begin
                    bit_valid = 1'b1; a_bit = a[i]; b_bit = b[i]; i--;
                end
            end else bit_valid = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; bit_valid = 1'b0;
        chk("done_seen", int'(done), 1);
        chk("latency", cyc, exp_lat(a, b, stall_at, nst));
        chk("gt", int'(greater_result), eg);
        chk("lt", int'(less), el);
        chk("eq", int'(equal), ee);
        chk("busy_done", int'(busy), 0);
        @(negedge clk);
        chk("done_pulse", int'(done), 0);
        chk("keep_gt", int'(greater_result), eg);
        pg = eg; pl = el; pe = ee;
    endtask

    vec_t tab[8];

    initial begin
        logic signed [W-1:0] sa, sb;
        tab[0] = '{6'b111101, 6'b000010, -1, 0, -1, 0, 1, 0};  // -3 vs 2
        tab[1] = '{6'b111111, 6'b100000, -1, 0, -1, 1, 0, 0};  // -1 vs -32
        tab[2] = '{6'b000101, 6'b000101,  3, 2, -1, 0, 0, 1};  // 5 vs 5, 2 stalls
        tab[3] = '{6'b011111, 6'b100000, -1, 0, -1, 1, 0, 0};  // 31 vs -32
        tab[4] = '{6'b000000, 6'b111111, -1, 0, -1, 1, 0, 0};  // 0 vs -1
        tab[5] = '{6'b100000, 6'b100000, -1, 0,  3, 0, 0, 1};  // -32 vs -32, start poked
        tab[6] = '{6'b010000, 6'b010001,  1, 1,  2, 0, 1, 0};  // 16 vs 17
        tab[7] = '{6'b111110, 6'b111111,  0, 1, -1, 0, 1, 0};  // -2 vs -1

        reset = 1'b1; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
        @(negedge clk);
        start = 1'b1;  // reset must win over start
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_gt", int'(greater_result), 0);
        chk("rst_lt", int'(less), 0);
        chk("rst_eq", int'(equal), 0);
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        for (int k = 0; k < 8; k++)
            run(tab[k].a, tab[k].b, tab[k].stall_at, tab[k].nst, tab[k].poke,
                tab[k].eg, tab[k].el, tab[k].ee);

        // reset in the middle of a compare drops everything
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b1;
            @(negedge clk);
        end
        chk("mid_busy", int'(busy), 1);
        reset = 1'b1; bit_valid = 1'b0;
        @(negedge clk);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_gt", int'(greater_result), 0);
        chk("mrst_lt", int'(less), 0);
        chk("mrst_eq", int'(equal), 0);
        reset = 1'b0;
        pg = 0; pl = 0; pe = 0;
        run(6'd1, 6'd0, -1, 0, -1, 1, 0, 0);

        // bit_valid outside a compare is ignored
        bit_valid = 1'b1; a_bit = 1'b0; b_bit = 1'b1;
        repeat (3) @(negedge clk);
        bit_valid = 1'b0;
        chk("idle_beats_busy", int'(busy), 0);
        chk("idle_beats_gt", int'(greater_result), 1);

        // full sweep against a signed reference
        for (int x = 0; x < (1 << W); x++)
            for (int y = 0; y < (1 << W); y++) begin
                sa = W'(x); sb = W'(y);
                run(W'(x), W'(y), -1, 0, -1, int'(sa > sb), int'(sa < sb), int'(sa == sb));
            end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
